// File: rtl/nbcac_enc_pipe.sv
// Pipelined numeral-based crosstalk-avoidance encoder: LANES independent K-bit words
// become N-wire Fibonacci-weighted codewords behind a valid/ready handshake.
module nbcac_enc_pipe #(
    parameter int N     = 7,
    parameter int K     = 5,
    parameter int LANES = 1,
    parameter int R     = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LANES*K-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [LANES*N-1:0] out_code,
    output logic               out_valid,
    input  logic               out_ready
);
    localparam int P = (N + R - 1) / R;

    // w1=1, wN=w(N-1)=2, wi=w(i+1)+w(i+2) going down from the top wire
    function automatic logic [31:0] weight(input int i);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        a = 32'd2;
        b = 32'd2;
        if (i == 1) return 32'd1;
        if (i >= N - 1) return 32'd2;
        for (int j = N - 2; j >= i; j--) begin
            t = a + b;
            b = a;
            a = t;
        end
        return a;
    endfunction

    localparam logic [31:0] W2 = weight(2);

    if (N < 4) begin : g_bad_n
        $error("nbcac_enc_pipe: N must be at least 4");
    end
    if (K < 1 || K > 30 || (32'd1 << K) > 2 * W2) begin : g_bad_k
        $error("nbcac_enc_pipe: K too wide for this N");
    end
    if (R < 1 || R > N) begin : g_bad_r
        $error("nbcac_enc_pipe: R must lie in 1..N");
    end
    if (LANES < 1) begin : g_bad_lanes
        $error("nbcac_enc_pipe: LANES must be at least 1");
    end

    logic [N-1:0] d_q  [P][LANES];
    logic [K-1:0] r_q  [P][LANES];
    logic [N-1:0] d_nx [P][LANES];
    logic [K-1:0] r_nx [P][LANES];
    logic [P-1:0] v_q;
    logic [P-1:0] up_v;
    logic [P-1:0] ld;
    logic         chain_full;
    logic [LANES-1:0] rem_unused;

    for (genvar k = 0; k < P; k++) begin : g_seg
        localparam int S = k * R + 1;
        localparam int E = (k * R + R < N) ? k * R + R : N;
        localparam int L = E - S + 1;
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            logic [N-1:0] dc [L+1];
            logic [K-1:0] rc [L+1];
            if (k == 0) begin : g_src_in
                assign dc[0] = '0;
                assign rc[0] = in_data[j*K +: K];
            end else begin : g_src_reg
                assign dc[0] = d_q[k-1][j];
                assign rc[0] = r_q[k-1][j];
            end
            for (genvar m = 0; m < L; m++) begin : g_stage
                localparam int I = S + m;
                localparam logic [N-1:0] MASK = N'(1) << (I - 1);
                logic         bit_d;
                logic [K-1:0] sub;
                if (I == 1) begin : g_lsb
                    assign bit_d = rc[m][0];
                    assign sub   = K'(1);
                end else if (I == N) begin : g_tail
                    assign bit_d = (rc[m] != '0);
                    assign sub   = '0;
                end else begin : g_mid
                    localparam logic [31:0] WI = weight(I);
                    localparam logic [31:0] WT = weight(I) + weight(I + 1);
                    logic [31:0] rx;
                    assign rx    = {{(32-K){1'b0}}, rc[m]};
                    // Ambiguous band [wi, wi+w(i+1)) repeats the previous bit to avoid 010/101 patterns
                    assign bit_d = (rx >= WT) || ((rx >= WI) && dc[m][I-2]);
                    assign sub   = WI[K-1:0];
                end
                assign dc[m+1] = bit_d ? (dc[m] | MASK) : dc[m];
                assign rc[m+1] = bit_d ? (rc[m] - sub) : rc[m];
            end
            assign d_nx[k][j] = dc[L];
            assign r_nx[k][j] = rc[L];
        end
    end

    always_comb begin
        up_v = '0;
        up_v[0] = in_valid;
        for (int k = 1; k < P; k++) begin
            up_v[k] = v_q[k-1];
        end
    end

    // A register can load unless it and everything downstream is full and the consumer stalls
    always_comb begin
        ld = '0;
        chain_full = 1'b1;
        for (int k = 0; k < P; k++) begin
            chain_full = 1'b1;
            for (int m = k; m < P; m++) begin
                chain_full = chain_full & v_q[m];
            end
            ld[k] = !chain_full || out_ready;
        end
    end

    // Payload only moves with a valid entry, so out_code holds the last codeword when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < P; k++) begin
                for (int j = 0; j < LANES; j++) begin
                    d_q[k][j] <= '0;
                    r_q[k][j] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < P; k++) begin
                if (ld[k]) begin
                    v_q[k] <= up_v[k];
                    if (up_v[k]) begin
                        for (int j = 0; j < LANES; j++) begin
                            d_q[k][j] <= d_nx[k][j];
                            r_q[k][j] <= r_nx[k][j];
                        end
                    end
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[P-1];

    for (genvar j = 0; j < LANES; j++) begin : g_out
        assign out_code[j*N +: N] = d_q[P-1][j];
        assign rem_unused[j]      = ^r_q[P-1][j];
    end

endmodule

// File: tb/tb_nbcac_enc_pipe.sv
// Self-checking bench: two encoder configurations driven with directed and random
// traffic, compared against a plain-arithmetic model of the greedy weighting rules.
module tb_nbcac_enc_pipe;
    localparam int PA = 7;
    localparam int PB = 3;

    logic        clk;
    logic        rst_n;
    logic [4:0]  a_in_data;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [6:0]  a_out_code;
    logic [23:0] b_in_data;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [35:0] b_out_code;

    int n_checks, n_fail, cyc, acc_a, acc_b;
    logic lat_on;
    logic [6:0]  qa_code[$];
    int          qa_val[$];
    int          qa_cyc[$];
    logic [35:0] qb_code[$];
    logic [23:0] qb_val[$];
    int          qb_cyc[$];
    logic [6:0]  a_last, a_prev;
    logic        a_stall;
    logic [35:0] b_last, b_prev;
    logic        b_stall;

    logic [4:0] dir_v [5] = '{5'd0, 5'd1, 5'd16, 5'd20, 5'd31};
    logic [6:0] dir_c [5] = '{7'b0000000, 7'b0000001, 7'b0001100, 7'b0011100, 7'b1100111};

    nbcac_enc_pipe #(.N(7), .K(5), .LANES(1), .R(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_code(a_out_code), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    nbcac_enc_pipe #(.N(9), .K(6), .LANES(4), .R(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_code(b_out_code), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic void weights(input int n, output int w[16]);
        for (int i = 0; i < 16; i++) w[i] = 0;
        w[1] = 1;
        w[n] = 2;
        w[n-1] = 2;
        for (int i = n - 2; i >= 2; i--) w[i] = w[i+1] + w[i+2];
    endfunction

    function automatic logic [15:0] ref_code(input int n, input int v);
        int w[16];
        int r;
        logic [15:0] d;
        weights(n, w);
        d = '0;
        d[0] = (v % 2) == 1;
        r = v - (v % 2);
        for (int i = 2; i <= n - 1; i++) begin
            if (r >= w[i] + w[i+1]) d[i-1] = 1'b1;
            else if (r < w[i]) d[i-1] = 1'b0;
            else d[i-1] = d[i-2];
            if (d[i-1]) r = r - w[i];
        end
        d[n-1] = (r != 0);
        return d;
    endfunction

    function automatic int wsum(input int n, input logic [15:0] d);
        int w[16];
        int s;
        weights(n, w);
        s = 0;
        for (int i = 1; i <= n; i++) if (d[i-1]) s += w[i];
        return s;
    endfunction

    function automatic logic [6:0] ref_a(input logic [4:0] v);
        logic [15:0] c;
        c = ref_code(7, int'(v));
        return c[6:0];
    endfunction

    function automatic logic [35:0] ref_b(input logic [23:0] data);
        logic [15:0] c;
        logic [5:0]  s;
        logic [35:0] e;
        e = '0;
        for (int j = 0; j < 4; j++) begin
            s = data[j*6 +: 6];
            c = ref_code(9, int'(s));
            e[j*9 +: 9] = c[8:0];
        end
        return e;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle on encoder A: drive at the falling edge, then check handshake and output
    task automatic step_a(input logic iv, input logic [4:0] data, input logic ordy, input logic [6:0] exp_code);
        logic [6:0] e;
        int v0, c0;
        @(negedge clk);
        a_in_valid = iv;
        a_in_data = data;
        a_out_ready = ordy;
        #1;
        check_output("a_in_ready", 64'(a_in_ready), 64'(!(qa_code.size() == PA && !ordy)));
        if (a_stall) begin
            check_output("a_stall_code", 64'(a_out_code), 64'(a_prev));
            check_output("a_stall_valid", 64'(a_out_valid), 64'd1);
        end
        if (!a_out_valid) check_output("a_idle_hold", 64'(a_out_code), 64'(a_last));
        if (a_out_valid && ordy) begin
            check_output("a_queue_nonempty", 64'(qa_code.size() != 0), 64'd1);
            if (qa_code.size() != 0) begin
                e = qa_code.pop_front();
                v0 = qa_val.pop_front();
                c0 = qa_cyc.pop_front();
                check_output("a_code", 64'(a_out_code), 64'(e));
                check_output("a_weight_sum", 64'(wsum(7, 16'(a_out_code))), 64'(v0));
                if (lat_on) check_output("a_latency", 64'(cyc - c0), 64'(PA));
                a_last = a_out_code;
            end
        end
        if (iv && a_in_ready) begin
            qa_code.push_back(exp_code);
            qa_val.push_back(int'(data));
            qa_cyc.push_back(cyc);
            acc_a++;
        end
        a_stall = a_out_valid && !ordy;
        a_prev = a_out_code;
        cyc++;
    endtask

    task automatic step_b(input logic iv, input logic [23:0] data, input logic ordy);
        logic [35:0] e;
        logic [23:0] v0;
        logic [5:0]  s;
        int c0;
        @(negedge clk);
        b_in_valid = iv;
        b_in_data = data;
        b_out_ready = ordy;
        #1;
        check_output("b_in_ready", 64'(b_in_ready), 64'(!(qb_code.size() == PB && !ordy)));
        if (b_stall) check_output("b_stall_code", 64'(b_out_code), 64'(b_prev));
        if (!b_out_valid) check_output("b_idle_hold", 64'(b_out_code), 64'(b_last));
        if (b_out_valid && ordy) begin
            check_output("b_queue_nonempty", 64'(qb_code.size() != 0), 64'd1);
            if (qb_code.size() != 0) begin
                e = qb_code.pop_front();
                v0 = qb_val.pop_front();
                c0 = qb_cyc.pop_front();
                check_output("b_code", 64'(b_out_code), 64'(e));
                for (int j = 0; j < 4; j++) begin
                    s = v0[j*6 +: 6];
                    check_output("b_lane_sum", 64'(wsum(9, 16'(b_out_code[j*9 +: 9]))), 64'(s));
                end
                if (lat_on) check_output("b_latency", 64'(cyc - c0), 64'(PB));
                b_last = b_out_code;
            end
        end
        if (iv && b_in_ready) begin
            qb_code.push_back(ref_b(data));
            qb_val.push_back(data);
            qb_cyc.push_back(cyc);
            acc_b++;
        end
        b_stall = b_out_valid && !ordy;
        b_prev = b_out_code;
        cyc++;
    endtask

    initial begin
        logic [4:0]  da;
        logic [23:0] db;
        int target, guard;
        n_checks = 0; n_fail = 0; cyc = 0; acc_a = 0; acc_b = 0;
        lat_on = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        a_last = '0; a_prev = '0; a_stall = 1'b0;
        b_last = '0; b_prev = '0; b_stall = 1'b0;
        rst_n = 1'b0;
        #12;
        check_output("a_reset_valid", 64'(a_out_valid), 64'd0);
        check_output("a_reset_code", 64'(a_out_code), 64'd0);
        check_output("a_reset_in_ready", 64'(a_in_ready), 64'd1);
        check_output("b_reset_valid", 64'(b_out_valid), 64'd0);
        check_output("b_reset_code", 64'(b_out_code), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vectors on A");
        lat_on = 1'b1;
        for (int i = 0; i < 5; i++) step_a(1'b1, dir_v[i], 1'b1, dir_c[i]);
        for (int i = 0; i < 10; i++) step_a(1'b0, 5'd0, 1'b1, 7'd0);

        $display("[TB] exhaustive back-to-back on A");
        for (int v = 0; v < 32; v++) step_a(1'b1, 5'(v), 1'b1, ref_a(5'(v)));
        for (int i = 0; i < 10; i++) step_a(1'b0, 5'd0, 1'b1, 7'd0);

        $display("[TB] random backpressure on A");
        lat_on = 1'b0;
        target = acc_a + 1000;
        guard = 0;
        while (acc_a < target && guard < 20000) begin
            da = 5'($urandom);
            step_a($urandom_range(0, 99) < 70, da, 1'($urandom_range(0, 1)), ref_a(da));
            guard++;
        end
        check_output("a_random_accepted", 64'(acc_a >= target), 64'd1);
        for (int i = 0; i < 30; i++) step_a(1'b0, 5'd0, 1'b1, 7'd0);
        check_output("a_drain_empty", 64'(qa_code.size()), 64'd0);

        $display("[TB] idle hold on A");
        step_a(1'b1, 5'd31, 1'b1, ref_a(5'd31));
        for (int i = 0; i < 17; i++) step_a(1'b0, 5'd0, 1'b1, 7'd0);
        check_output("a_hold_code", 64'(a_out_code), 64'(7'b1100111));
        check_output("a_hold_valid", 64'(a_out_valid), 64'd0);

        $display("[TB] reset mid-stream on A");
        step_a(1'b1, 5'd31, 1'b0, ref_a(5'd31));
        step_a(1'b1, 5'd9, 1'b0, ref_a(5'd9));
        step_a(1'b1, 5'd20, 1'b0, ref_a(5'd20));
        for (int i = 0; i < 8; i++) step_a(1'b0, 5'd0, 1'b0, 7'd0);
        check_output("a_pre_reset_code", 64'(a_out_code), 64'(ref_a(5'd31)));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("a_midrst_valid", 64'(a_out_valid), 64'd0);
        check_output("a_midrst_code", 64'(a_out_code), 64'd0);
        qa_code.delete(); qa_val.delete(); qa_cyc.delete();
        a_last = '0; a_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lat_on = 1'b1;
        step_a(1'b1, 5'd13, 1'b1, ref_a(5'd13));
        for (int i = 0; i < 10; i++) step_a(1'b0, 5'd0, 1'b1, 7'd0);
        check_output("a_post_reset_empty", 64'(qa_code.size()), 64'd0);

        $display("[TB] multi-lane encoder B");
        b_last = '0; b_stall = 1'b0;
        step_b(1'b1, {6'd21, 6'd42, 6'd63, 6'd0}, 1'b1);
        for (int i = 0; i < 6; i++) step_b(1'b0, 24'd0, 1'b1);
        check_output("b_directed_done", 64'(qb_code.size()), 64'd0);
        lat_on = 1'b0;
        target = acc_b + 300;
        guard = 0;
        while (acc_b < target && guard < 10000) begin
            db = 24'($urandom);
            step_b($urandom_range(0, 99) < 70, db, 1'($urandom_range(0, 1)));
            guard++;
        end
        check_output("b_random_accepted", 64'(acc_b >= target), 64'd1);
        for (int i = 0; i < 20; i++) step_b(1'b0, 24'd0, 1'b1);
        check_output("b_drain_empty", 64'(qb_code.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nbcac_enc_pipe.md
# nbcac_enc_pipe

Parametrised, pipelined numeral-based crosstalk-avoidance (NBCAC) encoder. It maps LANES independent K-bit data words onto LANES N-wire codewords using the greedy Fibonacci-weight algorithm with previous-bit tie-break. It streams through a valid/ready handshake with configurable register insertion. It sits between the source datapath and the bus drivers of a CAC-protected TSV/on-chip bus, and holds the last codeword on the wires while idle.

## Interface
- N, 7: codeword width per lane (N ≥ 4).
- K, 5: data width per lane. Legal iff 2^K ≤ 2·w2 (elaboration error otherwise). N=7 → K ≤ 5; N=9 → K ≤ 6.
- LANES, 1: independent encoder lanes sharing one handshake.
- R, 7: decision stages between pipeline registers, 1..N.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  LANES·K  data; lane j occupies bits [j·K+K-1 : j·K].
- in_valid  in  1  in_data valid.
- in_ready  out  1  encoder can accept this cycle.
- out_code  out  LANES·N  codewords; lane j bit j·N+(i-1) carries d_i.
- out_valid  out  1  out_code holds a new codeword.
- out_ready  in  1  consumer accepts out_code.

## Operation
- Weights: w1=1; wN=w(N-1)=2; wi=w(i+1)+w(i+2) for 2≤i≤N-2. N=7 gives 1,16,10,6,4,2,2.
- Per-lane algorithm on v (zero-extended to enough bits), computed at elaboration-sized width:
  - Stage 1: d1=v[0]; r1=v−d1.
  - Stage i, 2..N-1: d_i=1 if r(i-1) ≥ w_i+w(i+1); 0 if r(i-1) < w_i; else d_i=d(i-1). r_i=r(i-1)−d_i·w_i.
  - Stage N: d_N=(r(N-1)≠0).
- Property: Σ d_i·w_i = v for every legal v.
- Pipeline: stages 1..N are split into P=ceil(N/R) segments. A register follows each segment, and the last register drives out_code. Each register carries the partial d bits, the remainder r, and d of its last stage for every lane, plus one valid bit shared across lanes.
- Register k loads when its valid is 0 or register k+1 (or the consumer, for k=P) takes its contents this cycle. On load it takes upstream valid; otherwise it holds.
- in_ready = register 1 can load (combinational from downstream state; no in_valid→in_ready path).
- Bubbles collapse: an empty register loads even while downstream is stalled.
- out_code is updated only when the last register loads a valid entry. When the last register empties, out_code keeps the previous codeword and out_valid deasserts. The bus therefore sees no spurious transitions.
- No reordering or dropping; lanes never interact.

## Timing
- Reset (async assert, sync-released by the system): all valid bits 0, out_valid=0, out_code=0, internal d/r=0. in_ready=1 from the first cycle after release.
- Latency: a word accepted at edge t (in_valid&&in_ready) appears with out_valid=1 after edge t+P−1. So P=1 shows it in the cycle after acceptance.
- Throughput: 1 word/cycle with out_ready held high.
- Stall: out_valid=1 and out_ready=0 freeze out_code and every full register. in_ready falls only when all P registers are full.
- Simultaneous: in the same cycle the last register can be drained by out_ready and refilled from upstream. in_ready stays 1 through a full pipeline when out_ready=1.
- Reset mid-stream: all in-flight words are discarded and out_code goes to 0 immediately on rst_n low.
- in_data/in_valid are sampled only at acceptance. A change while in_ready=0 has no effect.

## Test plan
- N=7,K=5,R=7,LANES=1: v=0,1,16,20,31 streamed with out_ready=1 → out_code[6:0]=0000000,0000001,0001100,0011100,1100111, each one cycle after acceptance.
- N=7,R=2 (P=4): exhaustive v=0..31 back-to-back → every codeword meets Σd_i·w_i=v, matches the algorithm model, arrives 3 cycles after acceptance, and sustains 1/cycle.
- Backpressure: random out_ready (≈50%) with 1000 random words, R=1 → no loss, no duplication, order preserved. in_ready=0 exactly when all 7 registers are full, and out_code is stable whenever out_valid&&!out_ready.
- Idle hold: send v=31, then in_valid=0 for 10 cycles → out_code stays 1100111 with out_valid=0 after the consumer takes it.
- LANES=4, N=9, K=6: lanes carry 0,63,42,21 simultaneously → each lane slice is independently correct against the model.
- Pulse rst_n low mid-stream with 3 words in flight → out_valid=0 and out_code=0 immediately; the first word after release is encoded correctly with no residue.
